// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard controller state encoding, zero register index
// and default timing constants for the hazard controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_FREEZE = 2'd2,
    S_ERR    = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_INIT_CYCLES = 3;
  localparam int         DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. Optional performance counters
// are present only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
  // Level signals, sampled every cycle: no valid/ready handshake. Control
  // outputs are combinational from the controller state and the current inputs.
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       uses_rs_id;
  logic       uses_rt_id;
  logic       mem_read_ex;
  logic [4:0] rt_ex;
  logic       branch_taken_ex;
  logic       mem_req_mem;
  logic       dmem_ready;

  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_hold;
  logic       id_ex_flush;
  logic       ex_mem_hold;
  logic       mem_wb_bubble;
  logic       halted;
  logic       mem_timeout;
  cpu_pkg::hz_state_t state_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;
`endif

  modport master (
    input  rs_id, rt_id, uses_rs_id, uses_rt_id, mem_read_ex, rt_ex,
           branch_taken_ex, mem_req_mem, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush,
           ex_mem_hold, mem_wb_bubble, halted, mem_timeout, state_dbg
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, flush_cnt, freeze_cnt
`endif
  );

  modport slave (
    output rs_id, rt_id, uses_rs_id, uses_rt_id, mem_read_ex, rt_ex,
           branch_taken_ex, mem_req_mem, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush,
           ex_mem_hold, mem_wb_bubble, halted, mem_timeout, state_dbg
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, flush_cnt, freeze_cnt
`endif
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the ID instruction reads the register a
// load in EX is about to write. Writes to $zero never create a hazard.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rs_id,
  input  logic       uses_rt_id,
  input  logic       mem_read_ex,
  input  logic [4:0] rt_ex,
  output logic       load_use
);
  logic rs_match;
  logic rt_match;

  assign rs_match = uses_rs_id && (rs_id == rt_ex);
  assign rt_match = uses_rt_id && (rt_id == rt_ex);
  assign load_use = mem_read_ex && (rt_ex != REG_ZERO) && (rs_match || rt_match);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: init flush, load-use
// stalls, branch flushes, memory freeze and timeout halt. HAZARD_PERF_CNT_EN adds counters.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  hazard_ctrl_if.master  hif
);
  hz_state_t  state, state_nxt;
  logic [3:0] init_cnt, init_nxt;
  logic [7:0] frz_cnt, frz_nxt, frz_inc;
  logic       timeout_q, timeout_set;
  logic       load_use;
  logic       freeze;   // freeze outputs this cycle
  logic       run_hz;   // normal run: branch / load-use priorities apply
  logic       in_init, in_err;

  load_use_detect u_lud (
    .rs_id       (hif.rs_id),
    .rt_id       (hif.rt_id),
    .uses_rs_id  (hif.uses_rs_id),
    .uses_rt_id  (hif.uses_rt_id),
    .mem_read_ex (hif.mem_read_ex),
    .rt_ex       (hif.rt_ex),
    .load_use    (load_use)
  );

  assign frz_inc = (frz_cnt == 8'hFF) ? 8'hFF : frz_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      init_cnt  <= 4'd0;
      frz_cnt   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_nxt;
      frz_cnt  <= frz_nxt;
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    init_nxt    = init_cnt;
    frz_nxt     = frz_cnt;
    timeout_set = 1'b0;
    freeze      = 1'b0;
    run_hz      = 1'b0;
    in_init     = 1'b0;
    in_err      = 1'b0;
    case (state)
      S_INIT: begin
        in_init  = 1'b1;
        init_nxt = init_cnt + 4'd1;
        if (init_cnt == 4'(INIT_CYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (hif.mem_req_mem && !hif.dmem_ready) begin
          freeze    = 1'b1;
          frz_nxt   = 8'd1;
          state_nxt = S_FREEZE;
        end else begin
          run_hz = 1'b1;
        end
      end
      S_FREEZE: begin
        if (!hif.dmem_ready) begin
          freeze  = 1'b1;
          frz_nxt = frz_inc;
          if (frz_inc >= 8'(MEM_TIMEOUT)) begin
            state_nxt   = S_ERR;
            timeout_set = 1'b1;
          end
        end else begin
          run_hz    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: in_err = 1'b1;
    endcase
  end

  // Output muxing: a wrong-path ID instruction under a taken branch never stalls.
  always_comb begin
    hif.pc_write      = 1'b0;
    hif.if_id_write   = 1'b0;
    hif.if_id_flush   = 1'b0;
    hif.id_ex_hold    = 1'b0;
    hif.id_ex_flush   = 1'b0;
    hif.ex_mem_hold   = 1'b0;
    hif.mem_wb_bubble = 1'b0;
    hif.halted        = in_err;
    if (in_init) begin
      hif.if_id_flush   = 1'b1;
      hif.id_ex_flush   = 1'b1;
      hif.mem_wb_bubble = 1'b1;
    end
    if (freeze || in_err) begin
      hif.id_ex_hold    = 1'b1;
      hif.ex_mem_hold   = 1'b1;
      hif.mem_wb_bubble = 1'b1;
    end
    if (run_hz) begin
      hif.pc_write    = 1'b1;
      hif.if_id_write = 1'b1;
      if (hif.branch_taken_ex) begin
        hif.if_id_flush = 1'b1;
        hif.id_ex_flush = 1'b1;
      end else if (load_use) begin
        hif.pc_write    = 1'b0;
        hif.if_id_write = 1'b0;
        hif.id_ex_flush = 1'b1;
      end
    end
  end

  assign hif.mem_timeout = timeout_q;
  assign hif.state_dbg   = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q, freeze_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= 32'd0;
      flush_q  <= 32'd0;
      freeze_q <= 32'd0;
    end else begin
      if (run_hz && !hif.branch_taken_ex && load_use) stall_q <= stall_q + 32'd1;
      if (run_hz && hif.branch_taken_ex)              flush_q <= flush_q + 32'd1;
      if (freeze)                                     freeze_q <= freeze_q + 32'd1;
    end
  end

  assign hif.stall_cnt  = stall_q;
  assign hif.flush_cnt  = flush_q;
  assign hif.freeze_cnt = freeze_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each driven cycle pushes its
// expected control vector; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int W = 9;
  // {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush,
  //  ex_mem_hold, mem_wb_bubble, halted, mem_timeout}
  localparam logic [W-1:0] E_INIT  = 9'b001010100;
  localparam logic [W-1:0] E_RUN   = 9'b110000000;
  localparam logic [W-1:0] E_STALL = 9'b000010000;
  localparam logic [W-1:0] E_BR    = 9'b111010000;
  localparam logic [W-1:0] E_FRZ   = 9'b000101100;
  localparam logic [W-1:0] E_ERR   = 9'b000101111;

  logic clk;
  logic reset;
  hazard_ctrl_if hif ();

  hazard_ctrl #(.INIT_CYCLES(3), .MEM_TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_hold,
             hif.id_ex_flush, hif.ex_mem_hold, hif.mem_wb_bubble, hif.halted,
             hif.mem_timeout};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s act=%b exp=%b state=%0d t=%0t", t, act, e, hif.state_dbg, $time);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] rtex, input logic br,
                       input logic mq, input logic rdy,
                       input logic [W-1:0] e, input string tag);
    hif.rs_id = rs;  hif.uses_rs_id = urs;
    hif.rt_id = rt;  hif.uses_rt_id = urt;
    hif.mem_read_ex = mr; hif.rt_ex = rtex;
    hif.branch_taken_ex = br;
    hif.mem_req_mem = mq; hif.dmem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [W-1:0] e, input string tag);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, e, tag);
  endtask

  task automatic mem_wait(input logic [W-1:0] e, input string tag);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, e, tag);
  endtask

  task automatic check_val(input logic [31:0] act, input logic [31:0] e, input string tag);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, e);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    hif.rs_id = 5'd0; hif.rt_id = 5'd0; hif.uses_rs_id = 1'b0; hif.uses_rt_id = 1'b0;
    hif.mem_read_ex = 1'b0; hif.rt_ex = 5'd0; hif.branch_taken_ex = 1'b0;
    hif.mem_req_mem = 1'b0; hif.dmem_ready = 1'b1;
    @(posedge clk); #1;
    idle(E_INIT, "reset_hold");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(E_INIT, "init_seq");
    idle(E_RUN, "run_after_init");

    // load-use stalls and non-hazards
    drive(5'd8, 1'b1, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_STALL, "lu_rs");
    idle(E_RUN, "lu_rs_release");
    drive(5'd2, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, E_STALL, "lu_rt");
    drive(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, E_RUN, "lu_zero_reg");
    drive(5'd8, 1'b0, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_RUN, "lu_no_use");
    drive(5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1, E_RUN, "lu_no_load");

    // taken branch beats load-use
    drive(5'd8, 1'b1, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, E_BR, "br_over_lu");
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, E_BR, "br_alone");

    // five-cycle memory freeze, then ready
    for (int i = 0; i < 5; i++) mem_wait(E_FRZ, "freeze5");
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, E_RUN, "freeze_ready");
`ifdef HAZARD_PERF_CNT_EN
    check_val(hif.freeze_cnt, 32'd5, "perf_freeze");
    check_val(hif.stall_cnt, 32'd2, "perf_stall");
    check_val(hif.flush_cnt, 32'd2, "perf_flush");
`endif

    // freeze beats branch; ready cycle applies branch, then load-use on exit
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_FRZ, "frz_over_br");
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_BR, "frz_exit_br");
    mem_wait(E_FRZ, "frz_b");
    drive(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, E_STALL, "frz_exit_lu");

    // memory timeout: 64 freeze cycles then halt
    for (int i = 0; i < 70; i++) mem_wait(i < 64 ? E_FRZ : E_ERR, i < 64 ? "to_freeze" : "to_halt");
    idle(E_ERR, "halt_sticky");
    idle(E_ERR, "halt_sticky");

    // reset leaves the halt and restarts init
    reset = 1'b1;
    idle(E_INIT, "halt_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(E_INIT, "reinit_seq");
    idle(E_RUN, "reinit_run");

    // asynchronous reset mid-freeze
    mem_wait(E_FRZ, "mid_frz_a");
    mem_wait(E_FRZ, "mid_frz_b");
    reset = 1'b1;
    idle(E_INIT, "async_reset");
    idle(E_INIT, "async_reset_hold");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(E_INIT, "post_async_init");
    idle(E_RUN, "post_async_run");

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
